morse_decoder: RTL and testbench

- Consumes the dot/dash symbol stream and letter-spacing flag from the button-timing stage and assembles symbols into letters.
- On each letter boundary, looks up the symbol pattern and emits one ASCII character with a single-cycle valid strobe.
- Sits directly downstream of the button-timing stage and feeds the character display/UART stage.

---
 rtl/morse_decoder.sv | 162 ++++++++++++++++
 tb/tb_morse_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Assembles dot/dash symbols into letters and emits one ASCII character per letter gap.
// Optional macro WORD_SPACE_EN adds a space strobe after a long letter_spacing gap.
module morse_decoder #(
  parameter int MAX_SYMBOLS = 5,
  parameter int WORD_GAP    = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] morse_signal,
  input  logic       letter_spacing,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_error,
  output logic [2:0] symbol_count
);

  typedef enum logic [1:0] {
    SIG_NONE = 2'b00,
    SIG_DOT  = 2'b01,
    SIG_DASH = 2'b10,
    SIG_BAD  = 2'b11
  } sig_t;

  localparam logic [2:0] MAX_COUNT = 3'(MAX_SYMBOLS);

  logic [MAX_SYMBOLS-1:0] pattern, n_pattern;
  logic [2:0]             n_count;
  logic                   overflow, n_overflow;
  logic [1:0]             prev_sig;
  logic                   prev_ls;
  logic                   sym_event, letter_event, letter_fire;
  logic [8:0]             lut;

  // Returns {error, ascii}; pattern holds the first symbol at bit n-1, dash=1.
  function automatic logic [8:0] lookup(input logic [2:0] n, input logic [4:0] p);
    logic [4:0] key;
    key = p & ~(5'b11111 << n);
    case ({n, key})
      {3'd2, 5'b00001}: lookup = {1'b0, "A"};
      {3'd4, 5'b01000}: lookup = {1'b0, "B"};
      {3'd4, 5'b01010}: lookup = {1'b0, "C"};
      {3'd3, 5'b00100}: lookup = {1'b0, "D"};
      {3'd1, 5'b00000}: lookup = {1'b0, "E"};
      {3'd4, 5'b00010}: lookup = {1'b0, "F"};
      {3'd3, 5'b00110}: lookup = {1'b0, "G"};
      {3'd4, 5'b00000}: lookup = {1'b0, "H"};
      {3'd2, 5'b00000}: lookup = {1'b0, "I"};
      {3'd4, 5'b00111}: lookup = {1'b0, "J"};
      {3'd3, 5'b00101}: lookup = {1'b0, "K"};
      {3'd4, 5'b00100}: lookup = {1'b0, "L"};
      {3'd2, 5'b00011}: lookup = {1'b0, "M"};
      {3'd2, 5'b00010}: lookup = {1'b0, "N"};
      {3'd3, 5'b00111}: lookup = {1'b0, "O"};
      {3'd4, 5'b00110}: lookup = {1'b0, "P"};
      {3'd4, 5'b01101}: lookup = {1'b0, "Q"};
      {3'd3, 5'b00010}: lookup = {1'b0, "R"};
      {3'd3, 5'b00000}: lookup = {1'b0, "S"};
      {3'd1, 5'b00001}: lookup = {1'b0, "T"};
      {3'd3, 5'b00001}: lookup = {1'b0, "U"};
      {3'd4, 5'b00001}: lookup = {1'b0, "V"};
      {3'd3, 5'b00011}: lookup = {1'b0, "W"};
      {3'd4, 5'b01001}: lookup = {1'b0, "X"};
      {3'd4, 5'b01011}: lookup = {1'b0, "Y"};
      {3'd4, 5'b01100}: lookup = {1'b0, "Z"};
      {3'd5, 5'b11111}: lookup = {1'b0, "0"};
      {3'd5, 5'b01111}: lookup = {1'b0, "1"};
      {3'd5, 5'b00111}: lookup = {1'b0, "2"};
      {3'd5, 5'b00011}: lookup = {1'b0, "3"};
      {3'd5, 5'b00001}: lookup = {1'b0, "4"};
      {3'd5, 5'b00000}: lookup = {1'b0, "5"};
      {3'd5, 5'b10000}: lookup = {1'b0, "6"};
      {3'd5, 5'b11000}: lookup = {1'b0, "7"};
      {3'd5, 5'b11100}: lookup = {1'b0, "8"};
      {3'd5, 5'b11110}: lookup = {1'b0, "9"};
      default:          lookup = {1'b1, 8'h3F};
    endcase
  endfunction

  assign sym_event    = (morse_signal == SIG_DOT || morse_signal == SIG_DASH) &&
                        (morse_signal != prev_sig);
  assign letter_event = letter_spacing && !prev_ls;

  // A symbol arriving on the letter edge is appended before the decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    n_pattern  = pattern;
    n_count    = symbol_count;
    n_overflow = overflow;
    if (sym_event) begin
      if (symbol_count == MAX_COUNT) begin
        n_overflow = 1'b1;
      end else begin
        n_pattern = {pattern[MAX_SYMBOLS-2:0], morse_signal == SIG_DASH};
        n_count   = symbol_count + 3'd1;
      end
    end
    letter_fire = letter_event && (n_count != 3'd0);
    lut         = lookup(n_count, 5'(n_pattern));
  end

`ifdef WORD_SPACE_EN
  localparam int GAP_W = $clog2(WORD_GAP) + 1;

  logic [GAP_W-1:0] gap_cnt;
  logic             armed;
  logic             space_fire;

  assign space_fire = letter_spacing && armed && (gap_cnt == GAP_W'(WORD_GAP - 1));

  // armed remembers that a character went out since the last space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      if (!letter_spacing)                    gap_cnt <= '0;
      else if (gap_cnt != GAP_W'(WORD_GAP))   gap_cnt <= gap_cnt + 1'b1;
      if (letter_fire)                        armed <= 1'b1;
      else if (space_fire)                    armed <= 1'b0;
    end
  end
`else
  logic space_fire;
  assign space_fire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sig     <= SIG_NONE;
      prev_ls      <= 1'b0;
      pattern      <= '0;
      symbol_count <= 3'd0;
      overflow     <= 1'b0;
      char_valid   <= 1'b0;
      char_code    <= 8'h00;
      char_error   <= 1'b0;
    end else begin
      prev_sig   <= morse_signal;
      prev_ls    <= letter_spacing;
      char_valid <= 1'b0;
      char_error <= 1'b0;
      if (letter_fire) begin
        char_valid   <= 1'b1;
        char_code    <= n_overflow ? 8'h3F : lut[7:0];
        char_error   <= n_overflow | lut[8];
        pattern      <= '0;
        symbol_count <= 3'd0;
        overflow     <= 1'b0;
      end else begin
        pattern      <= n_pattern;
        symbol_count <= n_count;
        overflow     <= n_overflow;
        if (space_fire) begin
          char_valid <= 1'b1;
          char_code  <= 8'h20;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized scoreboard bench for morse_decoder: a driver pushes expected characters
// looked up from a Morse string table; a negedge monitor pops and compares strobes.
module tb_morse_decoder;

  localparam int MAX_SYMBOLS = 5;
  localparam int WORD_GAP    = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] morse_signal;
  logic       letter_spacing;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_error;
  logic [2:0] symbol_count;

  morse_decoder #(.MAX_SYMBOLS(MAX_SYMBOLS), .WORD_GAP(WORD_GAP)) dut (
    .clk(clk), .rst(rst), .morse_signal(morse_signal), .letter_spacing(letter_spacing),
    .char_valid(char_valid), .char_code(char_code), .char_error(char_error),
    .symbol_count(symbol_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] code;
    logic       err;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
`ifdef WORD_SPACE_EN
  bit   armed = 1'b0;
`endif

  string codes [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void ref_decode(input string pat, output logic [7:0] c, output logic e);
    c = 8'h3F;
    e = 1'b1;
    if (pat.len() <= MAX_SYMBOLS)
      for (int i = 0; i < 36; i++)
        if (codes[i] == pat) begin
          c = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
          e = 1'b0;
        end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raises letter_spacing (whatever morse_signal currently is) and books the result.
  task automatic raise_letter(input string pat, input int hold);
    logic [7:0] c;
    logic       e;
    int         rise;
    letter_spacing = 1'b1;
    rise = cyc;
    if (pat.len() > 0) begin
      ref_decode(pat, c, e);
      q.push_back('{c, e, rise + 1});
`ifdef WORD_SPACE_EN
      armed = 1'b1;
`endif
    end
`ifdef WORD_SPACE_EN
    if (hold >= WORD_GAP && armed) begin
      q.push_back('{8'h20, 1'b0, rise + WORD_GAP});
      armed = 1'b0;
    end
`endif
    tick(1);
    check("count_after_letter", symbol_count, 0);
    if (hold > 1) tick(hold - 1);
    morse_signal   = 2'b00;
    letter_spacing = 1'b0;
    tick(1);
  endtask

  task automatic send_letter(input string pat, input bit coincide, input int hold);
    logic [1:0] sym;
    for (int i = 0; i < pat.len(); i++) begin
      sym = (pat[i] == "-") ? 2'b10 : 2'b01;
      if (sym == morse_signal || $urandom_range(0, 2) == 0) begin
        morse_signal = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        tick($urandom_range(1, 3));
      end
      morse_signal = sym;
      if (coincide && i == pat.len() - 1) begin
        raise_letter(pat, hold);
        return;
      end
      tick(1);
      check("symbol_count", symbol_count, (i + 1 < MAX_SYMBOLS) ? i + 1 : MAX_SYMBOLS);
      tick($urandom_range(0, 3));
    end
    morse_signal = 2'b00;
    tick(1);
    raise_letter(pat, hold);
  endtask

  function automatic string random_pattern();
    string s;
    int    n;
    if ($urandom_range(0, 9) < 7) return codes[$urandom_range(0, 35)];
    s = "";
    n = $urandom_range(1, 7);
    for (int i = 0; i < n; i++) s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
    return s;
  endfunction

  // Monitor: every strobe must match the oldest booked character on its exact cycle.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (char_valid) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {24'h0, char_code}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("char_code", char_code, e.code);
          check("char_error", char_error, e.err);
          check("strobe_cycle", cyc, e.at);
        end
      end else begin
        check("error_idle_low", char_error, 0);
      end
    end
  end

  initial begin
    int wait_cycles;
    rst            = 1'b1;
    morse_signal   = 2'b00;
    letter_spacing = 1'b0;
    tick(2);
    check("reset_valid", char_valid, 0);
    check("reset_code", char_code, 8'h00);
    check("reset_error", char_error, 0);
    check("reset_count", symbol_count, 0);
    rst = 1'b0;
    tick(2);

    // Reset mid-letter discards the partial letter.
    morse_signal = 2'b01; tick(2);
    morse_signal = 2'b00; tick(1);
    morse_signal = 2'b01; tick(1);
    check("two_dots_count", symbol_count, 2);
    rst = 1'b1;
    #1;
    check("midreset_count", symbol_count, 0);
    check("midreset_valid", char_valid, 0);
    check("midreset_code", char_code, 8'h00);
    morse_signal = 2'b00;
    tick(1);
    rst = 1'b0;
    tick(1);
    raise_letter("", 3);

    // Directed letters and boundaries.
    send_letter(".-", 1'b0, 3);
    morse_signal = 2'b01; tick(50);
    morse_signal = 2'b10; tick(2);
    morse_signal = 2'b00; tick(1);
    raise_letter(".-", 2);
    send_letter("---", 1'b0, 2);
    send_letter("-----", 1'b0, 2);
    send_letter("......", 1'b0, 2);
    send_letter(".-.-", 1'b0, 2);
    send_letter("-.", 1'b1, 2);
    raise_letter("", 2);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    send_letter("...", 1'b0, 2);

    for (int n = 0; n < 80; n++)
      send_letter(random_pattern(), $urandom_range(0, 3) == 0, $urandom_range(1, 5));

`ifdef WORD_SPACE_EN
    send_letter(".", 1'b0, WORD_GAP + 50);
    raise_letter("", WORD_GAP + 50);
`endif

    wait_cycles = 0;
    while (q.size() != 0 && wait_cycles < 100) begin
      tick(1);
      wait_cycles++;
    end
    tick(3);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
